branch_resolve_queue: RTL
=========================

# branch_resolve_queue

In-order tracker that closes the loop for the global branch predictor. Each conditional-branch prediction made at fetch is pushed with its PC, predicted target and the GHR snapshot used to index the PHT. When execute resolves the oldest branch, the block compares outcome against prediction, issues a one-cycle update to the predictor, and on a mispredict raises flush/redirect with a repaired GHR. It sits between fetch/predict and execute in the MIPS pipeline.

## Interface
- DEPTH, 4, in-flight branch entries (power of two, ≥2)
- GHR_W, 12, global history width (matches predictor)
- CNT_W, 16, statistics counter width

- CLK  in  1  clock, rising edge
- RESET  in  1  asynchronous, active-low reset
- Pred_valid  in  1  fetch presents a conditional-branch prediction
- Pred_taken  in  1  predicted direction
- Pred_addr  in  32  branch PC
- Pred_target  in  32  predicted taken target
- Pred_ghr  in  GHR_W  GHR value used for this prediction
- Pred_ready  out  1  queue can accept a push this cycle
- Res_valid  in  1  execute resolves the oldest outstanding branch
- Res_taken  in  1  actual direction
- Res_target  in  32  actual taken target
- Upd_valid  out  1  one-cycle predictor-update strobe
- Upd_taken  out  1  actual direction, for PHT counter increment/decrement
- Upd_ghr  out  GHR_W  PHT index for the update (stored snapshot)
- Flush  out  1  one-cycle mispredict flush
- Redirect_addr  out  32  correct fetch PC, valid while Flush=1
- Recover_ghr  out  GHR_W  {stored_ghr[GHR_W-2:0], Res_taken}, valid while Flush=1
- Branch_count  out  CNT_W  resolved branches, saturating
- Mispredict_count  out  CNT_W  mispredicts, saturating
- Res_error  out  1  sticky: resolve arrived with queue empty

## Operation
- Circular FIFO: entry = {taken, addr, target, ghr}; wr_ptr, rd_ptr log2(DEPTH) bits, wrap modulo DEPTH; occupancy count 0..DEPTH.
- Pred_ready = (count != DEPTH); combinational from count only, no same-cycle pass-through.
- Push accepted when Pred_valid & Pred_ready; otherwise ignored, no state change.
- Pop when Res_valid & count != 0, always on the head entry.
- Mispredict = (Res_taken != head.taken) | (Res_taken & head.taken & Res_target != head.target).
- Redirect_addr = Res_target if Res_taken, else head.addr + 8 (past delay slot), 32-bit wrap.
- On every pop: Upd_valid=1, Upd_taken=Res_taken, Upd_ghr=head.ghr; Branch_count += 1 (saturate at all-ones).
- On mispredict pop: Flush=1, Redirect_addr, Recover_ghr driven; Mispredict_count += 1 (saturating); all remaining entries are wrong-path: count←0, rd_ptr←wr_ptr.
- Res_valid with count==0: no pop, no strobe, Res_error←1 until reset.

## Timing
- Reset (RESET=0, async): pointers, count, Upd_*, Flush, Redirect_addr, Recover_ghr, both counters, Res_error all 0; Pred_ready=1.
- Upd_*, Flush, Redirect_addr, Recover_ghr registered: asserted the cycle after the Res_valid edge, for exactly one cycle; Upd_ghr/Redirect_addr/Recover_ghr hold last value otherwise.
- Push latency: entry visible as head one cycle after accept; push and pop of the same entry in one cycle impossible (pop needs count≠0 before the edge).
- Simultaneous push and correct-pop: count unchanged, both pointers advance.
- Simultaneous push and mispredict-pop: pushed entry discarded (wrong path); count=0 after edge.
- Full and Res_valid: pop proceeds, Pred_ready rises next cycle.
- Reset asserted mid-operation: all entries dropped immediately, no Upd/Flush strobe generated.

## Test plan
- Reset then push 4 entries (addr 0x100,0x110,0x120,0x130, taken=1) -> Pred_ready=0 after 4th; 5th push ignored; count stays 4.
- Push addr 0x200 taken=1 target 0x400 ghr 0xABC; resolve taken, target 0x400 -> next cycle Upd_valid=1, Upd_taken=1, Upd_ghr=0xABC, Flush=0, Branch_count=1.
- Push addr 0x300 taken=1 ghr 0x001 plus two younger; resolve not-taken -> Flush=1, Redirect_addr=0x308, Recover_ghr=0x002, Mispredict_count=1, queue empty, Pred_ready=1.
- Predicted taken target 0x500, resolved taken target 0x600 -> Flush=1, Redirect_addr=0x600.
- Res_valid on empty queue -> no Upd_valid, Res_error=1 and stays 1 until RESET low.
- Branch_count preloaded to 0xFFFE via 0xFFFE correct resolves, then 3 more -> holds 0xFFFF; RESET low mid-stream -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/branch_resolve_queue.sv
// In-order queue of conditional-branch predictions awaiting resolution; on each
// resolve it strobes a predictor update and, on a mispredict, flushes and repairs the GHR.
module branch_resolve_queue #(
   parameter int DEPTH = 4,
   parameter int GHR_W = 12,
   parameter int CNT_W = 16
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             Pred_valid,
   input  logic             Pred_taken,
   input  logic [31:0]      Pred_addr,
   input  logic [31:0]      Pred_target,
   input  logic [GHR_W-1:0] Pred_ghr,
   output logic             Pred_ready,
   input  logic             Res_valid,
   input  logic             Res_taken,
   input  logic [31:0]      Res_target,
   output logic             Upd_valid,
   output logic             Upd_taken,
   output logic [GHR_W-1:0] Upd_ghr,
   output logic             Flush,
   output logic [31:0]      Redirect_addr,
   output logic [GHR_W-1:0] Recover_ghr,
   output logic [CNT_W-1:0] Branch_count,
   output logic [CNT_W-1:0] Mispredict_count,
   output logic             Res_error
);
   localparam int PW = $clog2(DEPTH);
   localparam logic [PW:0] FULL_C = (PW+1)'(DEPTH);

   logic             r_taken  [DEPTH];
   logic [31:0]      r_addr   [DEPTH];
   logic [31:0]      r_target [DEPTH];
   logic [GHR_W-1:0] r_ghr    [DEPTH];

   logic [PW-1:0] r_wr_ptr, r_rd_ptr;
   logic [PW:0]   r_count;

   logic             w_push, w_pop, w_mispred, w_push_eff;
   logic             w_head_taken;
   logic [31:0]      w_head_addr, w_head_target, w_redirect;
   logic [GHR_W-1:0] w_head_ghr;

   assign Pred_ready    = (r_count != FULL_C);
   assign w_push        = Pred_valid & Pred_ready;
   assign w_pop         = Res_valid & (r_count != '0);
   assign w_head_taken  = r_taken[r_rd_ptr];
   assign w_head_addr   = r_addr[r_rd_ptr];
   assign w_head_target = r_target[r_rd_ptr];
   assign w_head_ghr    = r_ghr[r_rd_ptr];
   assign w_mispred     = (Res_taken != w_head_taken) |
                          (Res_taken & w_head_taken & (Res_target != w_head_target));
   // A push racing a mispredict pop is on the wrong path and is dropped.
   assign w_push_eff    = w_push & ~(w_pop & w_mispred);
   assign w_redirect    = Res_taken ? Res_target : (w_head_addr + 32'd8);

   always_ff @(posedge CLK) begin
      if (w_push_eff) begin
         r_taken[r_wr_ptr]  <= Pred_taken;
         r_addr[r_wr_ptr]   <= Pred_addr;
         r_target[r_wr_ptr] <= Pred_target;
         r_ghr[r_wr_ptr]    <= Pred_ghr;
      end
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         r_wr_ptr         <= '0;
         r_rd_ptr         <= '0;
         r_count          <= '0;
         Upd_valid        <= 1'b0;
         Upd_taken        <= 1'b0;
         Upd_ghr          <= '0;
         Flush            <= 1'b0;
         Redirect_addr    <= '0;
         Recover_ghr      <= '0;
         Branch_count     <= '0;
         Mispredict_count <= '0;
         Res_error        <= 1'b0;
      end else begin
         Upd_valid <= w_pop;
         Flush     <= w_pop & w_mispred;
         if (w_push_eff)
            r_wr_ptr <= r_wr_ptr + PW'(1);
         if (w_pop & w_mispred) begin
            r_rd_ptr         <= r_wr_ptr;
            r_count          <= '0;
            Redirect_addr    <= w_redirect;
            Recover_ghr      <= {w_head_ghr[GHR_W-2:0], Res_taken};
            if (!(&Mispredict_count))
               Mispredict_count <= Mispredict_count + CNT_W'(1);
         end else begin
            if (w_pop)
               r_rd_ptr <= r_rd_ptr + PW'(1);
            case ({w_push_eff, w_pop})
               2'b10:   r_count <= r_count + (PW+1)'(1);
               2'b01:   r_count <= r_count - (PW+1)'(1);
               default: r_count <= r_count;
            endcase
         end
         if (w_pop) begin
            Upd_taken <= Res_taken;
            Upd_ghr   <= w_head_ghr;
            if (!(&Branch_count))
               Branch_count <= Branch_count + CNT_W'(1);
         end
         if (Res_valid && r_count == '0)
            Res_error <= 1'b1;
      end
   end
endmodule
